// File: rtl/spart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | spart_tx : SPART transmitter (baud divisor, tx buffer, 8N1/8E1 serialiser) |
// | Optional macro SPART_TX_PARITY_EN adds an even-parity bit (8E1 frames).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spart_tx #(
  parameter logic [15:0] DEFAULT_DIV = 16'd5208,
  parameter int          STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus_in,
  output logic       tbr,
  output logic       txd
);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t      state, state_nxt;
  logic [15:0] divisor;
  logic [15:0] eff_div;
  logic [15:0] baud_cnt;
  logic [7:0]  buffer;
  logic        buffer_full;
  logic [7:0]  shifter, shifter_nxt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic        parity;
  logic        wr, bit_tick, stop_done, transfer, txd_nxt;

  assign wr        = iocs & ~iorw;
  assign eff_div   = (divisor == 16'd0) ? 16'd1 : divisor;
  assign bit_tick  = (state != IDLE) && (baud_cnt == 16'd0);
  assign stop_done = (state == STOP) && bit_tick && (stop_cnt == LAST_STOP);
  // Refill straight out of the last stop bit so queued bytes leave no idle gap.
  assign transfer  = buffer_full && ((state == IDLE) || stop_done);
  assign tbr       = ~buffer_full;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (transfer) state_nxt = START;
      START:  if (bit_tick) state_nxt = DATA;
      DATA:   if (bit_tick && (bit_cnt == 3'd7)) begin
`ifdef SPART_TX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
`ifdef SPART_TX_PARITY_EN
      PARITY: if (bit_tick) state_nxt = STOP;
`endif
      STOP:   if (stop_done) state_nxt = transfer ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shifter_nxt = shifter;
    if (transfer)
      shifter_nxt = buffer;
    else if ((state == DATA) && bit_tick)
      shifter_nxt = {1'b0, shifter[7:1]};

    txd_nxt = 1'b1;
    case (state_nxt)
      START:  txd_nxt = 1'b0;
      DATA:   txd_nxt = shifter_nxt[0];
`ifdef SPART_TX_PARITY_EN
      PARITY: txd_nxt = parity;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      txd         <= 1'b1;
      divisor     <= DEFAULT_DIV;
      buffer      <= 8'd0;
      buffer_full <= 1'b0;
      shifter     <= 8'd0;
      baud_cnt    <= 16'd0;
      bit_cnt     <= 3'd0;
      stop_cnt    <= 1'b0;
      parity      <= 1'b0;
    end else begin
      state   <= state_nxt;
      txd     <= txd_nxt;
      shifter <= shifter_nxt;

      if (wr && (ioaddr == 2'b10)) divisor[7:0]  <= databus_in;
      if (wr && (ioaddr == 2'b11)) divisor[15:8] <= databus_in;

      if (transfer)
        buffer_full <= 1'b0;
      else if (wr && (ioaddr == 2'b00) && !buffer_full) begin
        buffer      <= databus_in;
        buffer_full <= 1'b1;
      end

      // Divisor is sampled only at reload, so a bit in flight is never cut short.
      if (transfer || bit_tick)
        baud_cnt <= eff_div - 16'd1;
      else if (state != IDLE)
        baud_cnt <= baud_cnt - 16'd1;

      if ((state == START) && bit_tick)
        bit_cnt <= 3'd0;
      else if ((state == DATA) && bit_tick)
        bit_cnt <= bit_cnt + 3'd1;

      if ((state == STOP) && bit_tick)
        stop_cnt <= stop_done ? 1'b0 : 1'b1;

`ifdef SPART_TX_PARITY_EN
      if (transfer)
        parity <= ^buffer;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_spart_tx : scoreboard bench for spart_tx (expected bit segments queued) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_spart_tx;
  localparam int STOP_BITS = 1;

  logic       clk = 1'b0;
  logic       rst, iocs, iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_in;
  logic       tbr, txd;

  spart_tx #(.DEFAULT_DIV(16'd5208), .STOP_BITS(STOP_BITS)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus_in(databus_in), .tbr(tbr), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   len;
    bit   sof;
    bit   contig;
  } seg_t;

  seg_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_busy = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic push_seg(input logic lvl, input int len, input bit sof, input bit contig);
    seg_t s;
    s.lvl = lvl; s.len = len; s.sof = sof; s.contig = contig;
    q.push_back(s);
  endtask

  // Bits with frame index >= sw (0 = start bit) last div_b clocks, the rest div_a.
  task automatic push_frame(input logic [7:0] d, input int div_a, input int div_b,
                            input int sw, input bit contig);
    int idx;
    idx = 0;
    push_seg(1'b0, (idx >= sw) ? div_b : div_a, 1'b1, contig); idx++;
    for (int i = 0; i < 8; i++) begin
      push_seg(d[i], (idx >= sw) ? div_b : div_a, 1'b0, 1'b0); idx++;
    end
`ifdef SPART_TX_PARITY_EN
    push_seg(^d, (idx >= sw) ? div_b : div_a, 1'b0, 1'b0); idx++;
`endif
    for (int i = 0; i < STOP_BITS; i++) begin
      push_seg(1'b1, (idx >= sw) ? div_b : div_a, 1'b0, 1'b0); idx++;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus_in = d;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((q.size() != 0 || mon_busy) && n < limit) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL %s: frame not completed, %0d segments left after %0d clocks, expected 0",
               name, q.size(), limit);
      q.delete();
    end
    #1;
  endtask

  // Monitor: waits for a start bit, then checks txd against each queued segment.
  initial begin : monitor
    seg_t s;
    int   waited;
    bit   bad, done;
    logic got;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        mon_busy = 1'b1;
        waited = 0;
        if (!(q[0].sof && q[0].contig)) begin
          while (txd !== 1'b0 && waited < 6000) begin
            @(negedge clk); waited++;
          end
        end
        if (waited >= 6000) begin
          checks++; errors++;
          $display("FAIL start_wait: txd=%b, expected start bit 0", txd);
          q.delete();
        end else begin
          done = 1'b0;
          while (!done) begin
            s = q.pop_front();
            bad = 1'b0; got = s.lvl;
            for (int i = 0; i < s.len; i++) begin
              if (i > 0) @(negedge clk);
              if (txd !== s.lvl && !bad) begin bad = 1'b1; got = txd; end
            end
            checks++;
            if (bad) begin
              errors++;
              $display("FAIL txd_segment: txd=%b, expected %b held %0d clocks", got, s.lvl, s.len);
            end
            if (q.size() == 0) done = 1'b1;
            else if (q[0].sof && !q[0].contig) done = 1'b1;
            else @(negedge clk);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stim
    int n;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; databus_in = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("reset_txd", txd, 1'b1);
    chk("reset_tbr", tbr, 1'b1);
    rst = 1'b0;

    // Read strobe to the buffer address must be ignored.
    @(posedge clk); #1;
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; databus_in = 8'h99;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
    chk("read_ignored_tbr", tbr, 1'b1);
    chk("read_ignored_txd", txd, 1'b1);

    // Test 1: divisor 4, byte A5, one-cycle tbr low.
    wr(2'b10, 8'd4);
    wr(2'b11, 8'd0);
    push_frame(8'hA5, 4, 4, 99, 1'b0);
    wr(2'b00, 8'hA5);
    chk("t1_tbr_low", tbr, 1'b0);
    @(posedge clk); #1;
    chk("t1_tbr_back", tbr, 1'b1);
    chk("t1_txd_start", txd, 1'b0);
    drain("t1_frame", 200);

    // Test 2: back-to-back frames, third write dropped.
    push_frame(8'h3C, 4, 4, 99, 1'b0);
    wr(2'b00, 8'h3C);
    n = 0;
    while (tbr !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    chk("t2_tbr_ready", tbr, 1'b1);
    push_frame(8'hC3, 4, 4, 99, 1'b1);
    wr(2'b00, 8'hC3);
    wr(2'b00, 8'hFF);
    chk("t2_tbr_full", tbr, 1'b0);
    drain("t2_frames", 300);
    repeat (2) @(posedge clk); #1;
    chk("t2_idle_txd", txd, 1'b1);
    chk("t2_idle_tbr", tbr, 1'b1);

    // Test 3: reset mid-frame with a byte buffered; divisor reverts to 5208.
    wr(2'b00, 8'h55);
    wr(2'b00, 8'hAA);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t3_rst_txd", txd, 1'b1);
    chk("t3_rst_tbr", tbr, 1'b1);
    push_seg(1'b0, 5208, 1'b1, 1'b0);
    push_seg(1'b1, 1, 1'b0, 1'b0);
    wr(2'b00, 8'h01);
    drain("t3_default_div", 6000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t3_rst2_txd", txd, 1'b1);

    // Test 4: divisor 0 behaves as 1.
    wr(2'b10, 8'd0);
    wr(2'b11, 8'd0);
    push_frame(8'hFF, 1, 1, 99, 1'b0);
    wr(2'b00, 8'hFF);
    drain("t4_div0", 100);

    // Test 5: divisor change during data bit 2 applies from bit 3.
    wr(2'b10, 8'd4);
    push_frame(8'h00, 4, 8, 4, 1'b0);
    wr(2'b00, 8'h00);
    repeat (12) @(posedge clk);
    wr(2'b10, 8'd8);
    drain("t5_div_change", 300);

`ifdef SPART_TX_PARITY_EN
    // Test 6: even parity bit.
    wr(2'b10, 8'd4);
    push_frame(8'h07, 4, 4, 99, 1'b0);
    wr(2'b00, 8'h07);
    drain("t6_parity1", 200);
    push_frame(8'h03, 4, 4, 99, 1'b0);
    wr(2'b00, 8'h03);
    drain("t6_parity0", 200);
`endif

    repeat (2) @(posedge clk); #1;
    chk("final_idle_txd", txd, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spart_tx.md
Name: spart_tx

Overview:
- Transmit half of the SPART, directly downstream of the processor-side bus driver.
- Owns the 16-bit baud divisor registers (DB_LOW at ioaddr 2'b10, DB_HIGH at ioaddr 2'b11) and the transmit buffer (ioaddr 2'b00).
- Serialises buffered bytes onto txd as 8N1 frames, or 8E1 with the optional feature.
- Reports buffer availability on tbr.

Parameters:
- DEFAULT_DIV, 16'd5208, divisor loaded at reset; clocks per serial bit.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- iocs  input  1  chip select from bus driver.
- iorw  input  1  1 = read, 0 = write.
- ioaddr  input  2  register address.
- databus_in  input  8  write data; the top level splits the tristate bus.
- tbr  output  1  transmit buffer ready; 1 = a write to 2'b00 will be accepted.
- txd  output  1  serial output, idle high, registered.

Behaviour:
- All state changes occur on posedge clk; rst is sampled synchronously.
- Reset values:
  - txd=1, tbr=1
  - divisor=DEFAULT_DIV
  - buffer empty, FSM=IDLE
  - baud and bit counters=0
- Write strobe `wr` = iocs & ~iorw.
- Reads (iorw=1) and ioaddr 2'b01 are ignored; status reads are decoded outside this block.
- Divisor writes:
  - `wr` & ioaddr 2'b10 loads divisor[7:0]; `wr` & ioaddr 2'b11 loads divisor[15:8].
  - A mid-frame divisor change takes effect at the next baud-counter reload; the current bit is never truncated.
  - Effective divisor 0 is treated as 1.
- Transmit buffer:
  - `wr` & ioaddr 2'b00 & tbr: byte latched into the 8-bit buffer, buffer_full=1, tbr=0 after that edge.
  - Write while tbr=0: dropped silently; buffer contents unchanged.
- Buffer-to-shifter transfer:
  - Occurs on the first edge where FSM is IDLE, or in the last clock of the final STOP bit, with buffer_full=1.
  - On transfer: shifter loads the buffer, buffer_full clears, tbr returns to 1 on the same edge.
- Latency: write accepted at edge E0 with FSM idle -> transfer at E1 -> txd=0 from E1, tbr back to 1 after E1.
- Back-to-back frames: a byte written during a frame starts its START bit immediately after the last stop bit, with no idle gap.
- Baud counter:
  - Loaded with divisor-1 on entry to START.
  - Counts down; `bit_tick` fires when the count is 0 and the counter reloads.
  - Every bit lasts exactly divisor clocks.
- FSM:
  - IDLE: txd=1; go to START on transfer.
  - START: txd=0; on bit_tick go to DATA with bit_cnt=0.
  - DATA: txd=shifter[0], LSB first; on bit_tick shift right and increment bit_cnt; after bit 7 go to PARITY (feature on) or STOP.
  - PARITY: txd=even parity of the byte; on bit_tick go to STOP.
  - STOP: txd=1 for STOP_BITS bit periods; then go to START if buffer_full, else IDLE.
- Simultaneous events:
  - Buffer write and transfer on the same edge cannot occur, because a write requires tbr=1, which implies the buffer is empty.
  - Divisor write during START/DATA is allowed; see the divisor rule above.
- Reset mid-frame: txd returns to 1 on the next edge; the frame is aborted, the buffer is discarded, and the divisor reverts to DEFAULT_DIV.

Optional Feature:
- SPART_TX_PARITY_EN
  - Defined: PARITY state is compiled in; frames are 11 bits (8E1) with an even-parity bit after the data bits.
  - Undefined: PARITY state and parity logic are absent; frames are 8N1, 10 bits with STOP_BITS=1.

Test Plan:
1. Reset, write DB_LOW=8'd4 and DB_HIGH=8'd0, write 8'hA5 to 2'b00 -> txd=0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks total); tbr=0 for exactly one cycle after the write.
2. Divisor 4; write 8'h3C, then write 8'hC3 as soon as tbr=1 -> two contiguous 40-clock frames with no idle high between the stop bit and the second start bit; a third write while tbr=0 is dropped.
3. Divisor 4; write 8'h55 and assert rst at clock 13 of the frame -> txd=1 the next cycle and tbr=1; a subsequent frame uses divisor 5208 (start bit lasts 5208 clocks).
4. Write DB_LOW=0 and DB_HIGH=0, send 8'hFF -> every bit lasts 1 clock; frame is 10 clocks.
5. Divisor 4; change DB_LOW to 8 during data bit 2 of a 8'h00 frame -> bit 2 is 4 clocks, bit 3 onward is 8 clocks.
6. SPART_TX_PARITY_EN defined, divisor 4, send 8'h07 -> parity bit=1; frame is 44 clocks. Send 8'h03 -> parity bit=0.
